fetch_unit: RTL

- Instruction fetch stage of the 32-bit processor. Owns the program counter, issues one instruction-memory read at a time over a req/ready handshake, and presents {instruction, PC} to decode.
- Sits directly upstream of the PC-select and operand 2:1 mux network. Decode raises branch_taken/branch_target to redirect fetch, and raises stall to hold the presented instruction.
- Wrong-path responses are squashed without violating the memory handshake.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and
// presents {instruction, PC} to decode, squashing wrong-path responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] pc_out_q, pc_out_d;

  logic consume;
  logic slot_free;

  assign consume   = inst_valid_q && !stall;
  assign slot_free = !inst_valid_q || !stall || branch_taken;

  assign imem_req   = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr  = req_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign pc_out     = pc_out_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    pc_out_d     = pc_out_q;

    case (state_q)
      IDLE: begin
        if (branch_taken) begin
          pc_d         = branch_target;
          inst_valid_d = 1'b0;
        end
        if (consume && !branch_taken) begin
          inst_valid_d = 1'b0;
        end
        if (slot_free) begin
          state_d    = FETCH;
          req_addr_d = branch_taken ? branch_target : pc_q;
        end
      end

      FETCH: begin
        if (imem_ready && !branch_taken) begin
          inst_out_d   = imem_rdata;
          pc_out_d     = req_addr_q;
          inst_valid_d = 1'b1;
          pc_d         = req_addr_q + PC_INC;
          state_d      = IDLE;
        end else if (imem_ready && branch_taken) begin
          // Response belongs to the old path; reissue at the target right away.
          pc_d       = branch_target;
          req_addr_d = branch_target;
        end else if (branch_taken) begin
          // Address must stay put until the outstanding request completes.
          pc_d    = branch_target;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (branch_taken) begin
          pc_d = branch_target;
        end
        if (imem_ready) begin
          req_addr_d = branch_taken ? branch_target : pc_q;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_out_q   <= 32'h0;
      pc_out_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      pc_out_q     <= pc_out_d;
    end
  end

endmodule
